// File: rtl/alarm_bank.sv
// alarm_bank - multi-channel BCD HH:MM alarm unit for the digital clock.
//
// Each channel stores one alarm time and runs its own IDLE/ARMED/RING/SNOOZE
// state machine. A channel is compared against the running clock only on the
// minute tick. Snooze and stop act on every channel together. Editing and
// arming act on the selected channel only.
//
// Ports
//   clk          system clock, all state on the rising edge
//   rst          asynchronous, active-high reset
//   cur_time     running clock time, BCD {hr tens[13:12], hr ones[11:8],
//                min tens[7:4], min ones[3:0]}
//   min_tick     1-cycle pulse; cur_time already holds the new minute
//   sel          channel being viewed / edited
//   set_en       edit mode; inc_hr / inc_min act only while high
//   inc_hr       selected alarm hour +1 (BCD mod 24)
//   inc_min      selected alarm minute +1 (BCD mod 60, no carry)
//   arm_toggle   toggle arm state of the selected channel
//   snooze       all RING channels -> SNOOZE
//   stop         all RING / SNOOZE channels -> ARMED
//   alarm_time   BCD time of the selected channel (00:00 for an invalid sel)
//   armed        per channel: in ARMED, RING or SNOOZE
//   ringing      per channel: in RING (registered)
//   ring         OR of ringing (registered)

module alarm_bank #(
  parameter int NUM_ALARMS       = 4,
  parameter int SNOOZE_MIN       = 5,
  parameter int RING_TIMEOUT_MIN = 10,
  localparam int SEL_W           = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [13:0]           cur_time,
  input  logic                  min_tick,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  set_en,
  input  logic                  inc_hr,
  input  logic                  inc_min,
  input  logic                  arm_toggle,
  input  logic                  snooze,
  input  logic                  stop,
  output logic [13:0]           alarm_time,
  output logic [NUM_ALARMS-1:0] armed,
  output logic [NUM_ALARMS-1:0] ringing,
  output logic                  ring
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMED  = 2'd1,
    S_RING   = 2'd2,
    S_SNOOZE = 2'd3
  } state_t;

  localparam logic [3:0] SNZ_LOAD    = 4'(SNOOZE_MIN);
  localparam logic [5:0] RING_LIMIT  = 6'(RING_TIMEOUT_MIN);
  localparam logic [SEL_W:0] NUM_SEL = (SEL_W + 1)'(NUM_ALARMS);

  state_t      state_q    [NUM_ALARMS];
  state_t      state_d    [NUM_ALARMS];
  logic [13:0] time_q     [NUM_ALARMS];
  logic [13:0] time_d     [NUM_ALARMS];
  logic [3:0]  snz_cnt_q  [NUM_ALARMS];
  logic [3:0]  snz_cnt_d  [NUM_ALARMS];
  logic [5:0]  ring_cnt_q [NUM_ALARMS];
  logic [5:0]  ring_cnt_d [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] sel_hit;
  logic [NUM_ALARMS-1:0] ringing_d;
  logic [NUM_ALARMS-1:0] ringing_q;
  logic                  ring_q;
  logic                  sel_valid;

  // Hours wrap 23 -> 00; otherwise the ones digit carries into the tens at 9.
  function automatic logic [13:0] bump_hour(input logic [13:0] t);
    logic [13:0] r;
    r = t;
    if (t[13:12] == 2'd2 && t[11:8] == 4'd3) begin
      r[13:8] = 6'h00;
    end else if (t[11:8] == 4'd9) begin
      r[13:12] = t[13:12] + 2'd1;
      r[11:8]  = 4'd0;
    end else begin
      r[11:8] = t[11:8] + 4'd1;
    end
    return r;
  endfunction

  // Minutes wrap 59 -> 00 without touching the hour field.
  function automatic logic [13:0] bump_minute(input logic [13:0] t);
    logic [13:0] r;
    r = t;
    if (t[7:4] == 4'd5 && t[3:0] == 4'd9) begin
      r[7:0] = 8'h00;
    end else if (t[3:0] == 4'd9) begin
      r[7:4] = t[7:4] + 4'd1;
      r[3:0] = 4'd0;
    end else begin
      r[3:0] = t[3:0] + 4'd1;
    end
    return r;
  endfunction

  // Out-of-range sel values select no channel, so edits and arming vanish
  // and the display shows 00:00.
  always_comb begin
    sel_valid = ({1'b0, sel} < NUM_SEL);
    for (int i = 0; i < NUM_ALARMS; i++) begin
      sel_hit[i] = sel_valid && (sel == SEL_W'(i));
    end
  end

  always_comb begin
    alarm_time = 14'h0000;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      if (sel_hit[i]) alarm_time = time_q[i];
    end
  end

  // NOTE: every signal driven here gets its hold value first, so no path
  // through the if/else chain can leave one unassigned and infer a latch.
  always_comb begin
    for (int i = 0; i < NUM_ALARMS; i++) begin
      state_d[i]    = state_q[i];
      time_d[i]     = time_q[i];
      snz_cnt_d[i]  = snz_cnt_q[i];
      ring_cnt_d[i] = ring_cnt_q[i];

      // Editing is locked out only while the channel is actually ringing.
      if (set_en && sel_hit[i] && state_q[i] != S_RING) begin
        if (inc_hr)  time_d[i] = bump_hour(time_d[i]);
        if (inc_min) time_d[i] = bump_minute(time_d[i]);
      end

      // Only the highest-priority applicable event acts; the rest are dropped.
      if (arm_toggle && sel_hit[i]) begin
        state_d[i] = (state_q[i] == S_IDLE) ? S_ARMED : S_IDLE;
      end else if (stop && (state_q[i] == S_RING || state_q[i] == S_SNOOZE)) begin
        state_d[i] = S_ARMED;
      end else if (snooze && state_q[i] == S_RING) begin
        state_d[i]   = S_SNOOZE;
        snz_cnt_d[i] = SNZ_LOAD;
      end else if (min_tick) begin
        case (state_q[i])
          S_ARMED: begin
            if (cur_time == time_q[i]) begin
              state_d[i]    = S_RING;
              ring_cnt_d[i] = 6'd0;
            end
          end
          S_RING: begin
            ring_cnt_d[i] = ring_cnt_q[i] + 6'd1;
            if (ring_cnt_q[i] + 6'd1 == RING_LIMIT) state_d[i] = S_ARMED;
          end
          S_SNOOZE: begin
            snz_cnt_d[i] = snz_cnt_q[i] - 4'd1;
            if (snz_cnt_q[i] == 4'd1) begin
              state_d[i]    = S_RING;
              ring_cnt_d[i] = 6'd0;
            end
          end
          default: ;
        endcase
      end

      ringing_d[i] = (state_d[i] == S_RING);
    end
  end

  // NOTE: the stored alarm times are cleared by reset like any other flop;
  // a power-on alarm must read 00:00, not whatever the register array held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        state_q[i]    <= S_IDLE;
        time_q[i]     <= 14'h0000;
        snz_cnt_q[i]  <= 4'd0;
        ring_cnt_q[i] <= 6'd0;
      end
      ringing_q <= '0;
      ring_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every flop samples pre-edge values.
      for (int i = 0; i < NUM_ALARMS; i++) begin
        state_q[i]    <= state_d[i];
        time_q[i]     <= time_d[i];
        snz_cnt_q[i]  <= snz_cnt_d[i];
        ring_cnt_q[i] <= ring_cnt_d[i];
      end
      ringing_q <= ringing_d;
      ring_q    <= |ringing_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_ALARMS; i++) begin
      armed[i] = (state_q[i] != S_IDLE);
    end
  end

  assign ringing = ringing_q;
  assign ring    = ring_q;

endmodule

// File: tb/tb_alarm_bank.sv
// tb_alarm_bank - directed, table-driven bench for alarm_bank.
// A main instance (4 channels) is exercised through edit, ring, timeout,
// snooze, stop, multi-channel and reset scenarios. A second 5-channel
// instance is held at sel=5 to show an out-of-range select is inert.

module tb_alarm_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] cur_time;
  logic        min_tick;
  logic [1:0]  sel;
  logic        set_en, inc_hr, inc_min, arm_toggle, snooze, stop;
  logic [13:0] alarm_time;
  logic [3:0]  armed, ringing;
  logic        ring;

  logic [2:0]  sel2;
  logic [13:0] alarm_time2;
  logic [4:0]  armed2, ringing2;
  logic        ring2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alarm_bank dut (
    .clk(clk), .rst(rst), .cur_time(cur_time), .min_tick(min_tick), .sel(sel),
    .set_en(set_en), .inc_hr(inc_hr), .inc_min(inc_min), .arm_toggle(arm_toggle),
    .snooze(snooze), .stop(stop), .alarm_time(alarm_time), .armed(armed),
    .ringing(ringing), .ring(ring)
  );

  alarm_bank #(.NUM_ALARMS(5)) dut5 (
    .clk(clk), .rst(rst), .cur_time(cur_time), .min_tick(min_tick), .sel(sel2),
    .set_en(set_en), .inc_hr(inc_hr), .inc_min(inc_min), .arm_toggle(arm_toggle),
    .snooze(snooze), .stop(stop), .alarm_time(alarm_time2), .armed(armed2),
    .ringing(ringing2), .ring(ring2)
  );

  typedef struct {
    logic [13:0] ct;
    logic        tick;
    logic        tog;
    logic        snz;
    logic        stp;
    logic [13:0] exp_time;
    logic [3:0]  exp_armed;
    logic [3:0]  exp_ringing;
    logic        exp_ring;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // One clock edge, then sample 1 time unit later and drop the pulse inputs.
  task automatic step();
    @(posedge clk);
    #1;
    min_tick   = 1'b0;
    inc_hr     = 1'b0;
    inc_min    = 1'b0;
    arm_toggle = 1'b0;
    snooze     = 1'b0;
    stop       = 1'b0;
  endtask

  function automatic vec_t mk(input logic [13:0] ct, input logic tick, tog, snz, stp,
                              input logic [3:0] ea, er, input logic erg);
    vec_t v;
    v.ct = ct; v.tick = tick; v.tog = tog; v.snz = snz; v.stp = stp;
    v.exp_time = 14'h0730; v.exp_armed = ea; v.exp_ringing = er; v.exp_ring = erg;
    return v;
  endfunction

  initial begin
    rst = 1'b1; cur_time = 14'h1234; min_tick = 0; sel = 0; sel2 = 3'd5;
    set_en = 0; inc_hr = 0; inc_min = 0; arm_toggle = 0; snooze = 0; stop = 0;

    // Reset state
    #12;
    check("rst_time", alarm_time, 14'h0000);
    check("rst_armed", {10'd0, armed}, 14'd0);
    check("rst_ringing", {10'd0, ringing}, 14'd0);
    check("rst_ring", {13'd0, ring}, 14'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Set channel 0 to 07:30 and arm it
    set_en = 1;
    for (int k = 0; k < 7; k++) begin inc_hr = 1; step(); end
    check("set_hr_0700", alarm_time, 14'h0700);
    for (int k = 0; k < 30; k++) begin inc_min = 1; step(); end
    check("set_min_0730", alarm_time, 14'h0730);
    set_en = 0;
    arm_toggle = 1; step();
    check("arm_ch0", {10'd0, armed}, 14'h0001);

    // Ring, timeout, snooze, stop, re-arm sequence on channel 0
    vecs.push_back(mk(14'h0730, 1, 0, 0, 0, 4'b0001, 4'b0001, 1));
    for (int k = 0; k < 9; k++) vecs.push_back(mk(14'h0731, 1, 0, 0, 0, 4'b0001, 4'b0001, 1));
    vecs.push_back(mk(14'h0731, 1, 0, 0, 0, 4'b0001, 4'b0000, 0));   // 10th tick: timeout
    vecs.push_back(mk(14'h0731, 1, 0, 0, 0, 4'b0001, 4'b0000, 0));
    vecs.push_back(mk(14'h0730, 1, 0, 0, 0, 4'b0001, 4'b0001, 1));   // match again
    vecs.push_back(mk(14'h0731, 0, 0, 1, 0, 4'b0001, 4'b0000, 0));   // snooze
    for (int k = 0; k < 4; k++) vecs.push_back(mk(14'h0731, 1, 0, 0, 0, 4'b0001, 4'b0000, 0));
    vecs.push_back(mk(14'h0731, 1, 0, 0, 0, 4'b0001, 4'b0001, 1));   // 5th tick: ring again
    vecs.push_back(mk(14'h0730, 0, 0, 0, 1, 4'b0001, 4'b0000, 0));   // stop
    vecs.push_back(mk(14'h0730, 0, 0, 0, 0, 4'b0001, 4'b0000, 0));   // no re-ring same minute
    vecs.push_back(mk(14'h0731, 0, 1, 0, 0, 4'b0000, 4'b0000, 0));   // disarm
    vecs.push_back(mk(14'h0730, 0, 1, 0, 0, 4'b0001, 4'b0000, 0));   // re-arm inside matching minute
    vecs.push_back(mk(14'h0731, 1, 0, 0, 0, 4'b0001, 4'b0000, 0));   // next tick does not ring

    sel = 0; set_en = 0;
    foreach (vecs[i]) begin
      cur_time = vecs[i].ct; min_tick = vecs[i].tick; arm_toggle = vecs[i].tog;
      snooze = vecs[i].snz; stop = vecs[i].stp;
      step();
      check($sformatf("vec%0d_time", i), alarm_time, vecs[i].exp_time);
      check($sformatf("vec%0d_armed", i), {10'd0, armed}, {10'd0, vecs[i].exp_armed});
      check($sformatf("vec%0d_ringing", i), {10'd0, ringing}, {10'd0, vecs[i].exp_ringing});
      check($sformatf("vec%0d_ring", i), {13'd0, ring}, {13'd0, vecs[i].exp_ring});
    end
    cur_time = 14'h1234;

    // BCD wrap on channel 1
    sel = 1; set_en = 1;
    for (int k = 0; k < 23; k++) begin inc_hr = 1; inc_min = 1; step(); end
    check("both_2323", alarm_time, 14'h2323);
    for (int k = 0; k < 36; k++) begin inc_min = 1; step(); end
    check("min_2359", alarm_time, 14'h2359);
    inc_min = 1; step();
    check("min_wrap_2300", alarm_time, 14'h2300);
    inc_hr = 1; step();
    check("hr_wrap_0000", alarm_time, 14'h0000);
    for (int k = 0; k < 9; k++) begin inc_hr = 1; step(); end
    check("hr_0900", alarm_time, 14'h0900);
    inc_hr = 1; step();
    check("hr_1000", alarm_time, 14'h1000);
    for (int k = 0; k < 9; k++) begin inc_hr = 1; step(); end
    check("hr_1900", alarm_time, 14'h1900);
    inc_hr = 1; step();
    check("hr_2000", alarm_time, 14'h2000);
    inc_hr = 1; inc_min = 1; step();
    check("both_2101", alarm_time, 14'h2101);
    check("ch1_not_armed", {10'd0, armed}, 14'h0001);

    // Edits ignored while ringing, applied while snoozing
    sel = 0; set_en = 0; cur_time = 14'h0730; min_tick = 1; step();
    check("edit_ring_start", {10'd0, ringing}, 14'h0001);
    set_en = 1; inc_hr = 1; inc_min = 1; step();
    check("edit_on_ring", alarm_time, 14'h0730);
    check("edit_on_ring_still", {10'd0, ringing}, 14'h0001);
    snooze = 1; step();
    check("snooze_off", {10'd0, ringing}, 14'h0000);
    inc_min = 1; step();
    check("edit_on_snooze", alarm_time, 14'h0731);
    check("snooze_armed", {10'd0, armed}, 14'h0001);

    // Asynchronous reset mid-snooze
    #3 rst = 1'b1;
    #1;
    check("async_rst_armed", {10'd0, armed}, 14'h0000);
    check("async_rst_ringing", {10'd0, ringing}, 14'h0000);
    check("async_rst_ring", {13'd0, ring}, 14'h0000);
    check("async_rst_time", alarm_time, 14'h0000);
    @(posedge clk); #1 rst = 1'b0;

    // Two channels at 06:00 ring together; stop + disarm on the same cycle
    sel = 0; set_en = 1; cur_time = 14'h1234;
    for (int k = 0; k < 6; k++) begin inc_hr = 1; step(); end
    set_en = 0; arm_toggle = 1; step();
    sel = 2; set_en = 1;
    for (int k = 0; k < 6; k++) begin inc_hr = 1; step(); end
    check("ch2_0600", alarm_time, 14'h0600);
    set_en = 0; arm_toggle = 1; step();
    check("two_armed", {10'd0, armed}, 14'h0005);
    cur_time = 14'h0600; min_tick = 1; step();
    check("two_ringing", {10'd0, ringing}, 14'h0005);
    check("two_ring", {13'd0, ring}, 14'h0001);
    stop = 1; arm_toggle = 1; step();
    check("stop_tog_armed", {10'd0, armed}, 14'h0001);
    check("stop_tog_ringing", {10'd0, ringing}, 14'h0000);
    check("stop_tog_ring", {13'd0, ring}, 14'h0000);

    // Out-of-range select on the 5-channel instance
    set_en = 1; inc_hr = 1; inc_min = 1; arm_toggle = 1; step();
    check("sel5_time", alarm_time2, 14'h0000);
    check("sel5_armed", {9'd0, armed2}, 14'h0000);
    check("sel5_ringing", {9'd0, ringing2}, 14'h0000);
    sel2 = 3'd4; step();
    check("sel4_time", alarm_time2, 14'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
